// File: rtl/game_pkg.sv
// Shared game definitions: state encoding and scoring thresholds used by the
// controller and by the drawing stages.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        PLAYER = 3'b001,
        DEALER = 3'b010,
        WIN    = 3'b011,
        LOSE   = 3'b100,
        DRAW   = 3'b101,
        DEAL   = 3'b110
    } state_t;

    localparam int DEALER_STAND = 17;
    localparam int BLACKJACK    = 21;
    localparam int DEAL_CARDS   = 3;

    // Opening deal order is player, dealer, player.
    function automatic logic deal_target(input logic [1:0] idx);
        return (idx == 2'd1);
    endfunction

endpackage

// File: rtl/game_fsm_btn_edge.sv
// Registered rising-edge detector for an already-synchronised button level.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic prev;
    logic armed;

    // The first cycle after reset only samples history, so a button held
    // through reset release never looks like a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= 1'b0;
            armed <= 1'b0;
            rise  <= 1'b0;
        end else begin
            prev  <= btn;
            armed <= 1'b1;
            rise  <= armed & btn & ~prev;
        end
    end

endmodule

// File: rtl/game_fsm.sv
// Blackjack round controller: deals, handles player hit/stand, plays the
// dealer and resolves the hand, driving a one-card-at-a-time draw handshake.
module game_fsm
    import game_pkg::*;
#(
    parameter int SCORE_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_start,
    input  logic               btn_hit,
    input  logic               btn_stand,
    input  logic [SCORE_W-1:0] player_score,
    input  logic [SCORE_W-1:0] dealer_score,
    input  logic               draw_ack,
    output logic               draw_req,
    output logic               draw_target,
    output logic               clear_hands,
    output logic [2:0]         state
);

    localparam logic [SCORE_W-1:0] STAND_LIM = SCORE_W'(DEALER_STAND);
    localparam logic [SCORE_W-1:0] BJ_LIM    = SCORE_W'(BLACKJACK);

    state_t     cur;
    logic [1:0] deal_cnt;
    logic       pending;
    logic       settle;
    logic       start_rise;
    logic       hit_rise;
    logic       stand_rise;

    btn_edge u_start (.clk(clk), .rst(rst), .btn(btn_start), .rise(start_rise));
    btn_edge u_hit   (.clk(clk), .rst(rst), .btn(btn_hit),   .rise(hit_rise));
    btn_edge u_stand (.clk(clk), .rst(rst), .btn(btn_stand), .rise(stand_rise));

    assign state = cur;

    // While a card is outstanding or settling, the state logic is frozen and
    // any button pulses in that window are simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur         <= IDLE;
            draw_req    <= 1'b0;
            draw_target <= 1'b0;
            clear_hands <= 1'b0;
            deal_cnt    <= 2'd0;
            pending     <= 1'b0;
            settle      <= 1'b0;
        end else begin
            clear_hands <= 1'b0;
            if (pending) begin
                if (draw_ack) begin
                    draw_req <= 1'b0;
                    pending  <= 1'b0;
                    settle   <= 1'b1;
                end
            end else if (settle) begin
                settle <= 1'b0;
            end else begin
                case (cur)
                    IDLE, WIN, LOSE, DRAW: begin
                        if (start_rise) begin
                            clear_hands <= 1'b1;
                            deal_cnt    <= 2'd0;
                            cur         <= DEAL;
                        end
                    end
                    DEAL: begin
                        if (deal_cnt == 2'(DEAL_CARDS)) begin
                            deal_cnt <= 2'd0;
                            cur      <= PLAYER;
                        end else begin
                            draw_req    <= 1'b1;
                            draw_target <= deal_target(deal_cnt);
                            pending     <= 1'b1;
                            deal_cnt    <= deal_cnt + 2'd1;
                        end
                    end
                    PLAYER: begin
                        if (player_score > BJ_LIM) begin
                            cur <= LOSE;
                        end else if (player_score == BJ_LIM) begin
                            cur <= DEALER;
                        end else if (stand_rise) begin
                            cur <= DEALER;
                        end else if (hit_rise) begin
                            draw_req    <= 1'b1;
                            draw_target <= 1'b0;
                            pending     <= 1'b1;
                        end
                    end
                    DEALER: begin
                        if (dealer_score < STAND_LIM) begin
                            draw_req    <= 1'b1;
                            draw_target <= 1'b1;
                            pending     <= 1'b1;
                        end else if (dealer_score > BJ_LIM) begin
                            cur <= WIN;
                        end else if (player_score > dealer_score) begin
                            cur <= WIN;
                        end else if (player_score < dealer_score) begin
                            cur <= LOSE;
                        end else begin
                            cur <= DRAW;
                        end
                    end
                    default: cur <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_fsm.sv
// Self-checking bench for game_fsm: scenario tasks with a queue of expected
// draw targets consumed as the controller issues requests.
module tb_game_fsm;
    import game_pkg::*;

    localparam int SW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          btn_start = 1'b0;
    logic          btn_hit = 1'b0;
    logic          btn_stand = 1'b0;
    logic [SW-1:0] player_score = '0;
    logic [SW-1:0] dealer_score = '0;
    logic          draw_ack = 1'b0;
    logic          draw_req;
    logic          draw_target;
    logic          clear_hands;
    logic [2:0]    state;

    int   checks = 0;
    int   errors = 0;
    logic exp_tgt_q[$];

    game_fsm #(.SCORE_W(SW)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_hit(btn_hit),
        .btn_stand(btn_stand), .player_score(player_score),
        .dealer_score(dealer_score), .draw_ack(draw_ack), .draw_req(draw_req),
        .draw_target(draw_target), .clear_hands(clear_hands), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits (bounded) for a request and checks its target against the queue.
    task automatic wait_req();
        int   n = 0;
        logic exp;
        while (draw_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        exp = (exp_tgt_q.size() > 0) ? exp_tgt_q.pop_front() : 1'b0;
        checks++;
        if (draw_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL req_timeout: draw_req=%b required 1", draw_req);
        end else if (draw_target !== exp) begin
            errors++;
            $display("[TB] FAIL draw_target: got %b required %b", draw_target, exp);
        end
    endtask

    // Card generator model: acks lat cycles after the request, updating scores.
    task automatic serve(input int lat, input logic [SW-1:0] p, input logic [SW-1:0] d);
        logic stable = 1'b1;
        logic t;
        wait_req();
        t = draw_target;
        repeat (lat - 1) begin
            tick();
            if (draw_req !== 1'b1 || draw_target !== t) stable = 1'b0;
        end
        draw_ack = 1'b1;
        player_score = p;
        dealer_score = d;
        tick();
        draw_ack = 1'b0;
        checks++;
        if (!stable || draw_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL handshake: stable=%b draw_req_after_ack=%b required 1/0",
                     stable, draw_req);
        end
    endtask

    task automatic start_round();
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
        tick();
        checks++;
        if (clear_hands !== 1'b1 || state !== 3'b110) begin
            errors++;
            $display("[TB] FAIL start: clear_hands=%b state=%b required 1/110", clear_hands, state);
        end
        tick();
        checks++;
        if (clear_hands !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_pulse_width: clear_hands=%b required 0", clear_hands);
        end
    endtask

    task automatic deal_round(input logic [SW-1:0] p, input logic [SW-1:0] d);
        start_round();
        exp_tgt_q.push_back(1'b0);
        exp_tgt_q.push_back(1'b1);
        exp_tgt_q.push_back(1'b0);
        serve(2, p / 2, d);
        serve(2, p / 2, d);
        serve(2, p, d);
        checks++;
        if (state !== 3'b110) begin
            errors++;
            $display("[TB] FAIL deal_hold: state=%b required 110", state);
        end
        tick(2);
        checks++;
        if (state !== 3'b001) begin
            errors++;
            $display("[TB] FAIL deal_done: state=%b required 001", state);
        end
    endtask

    task automatic test_reset();
        logic quiet = 1'b1;
        rst = 1'b1;
        btn_start = 1'b1;
        tick(3);
        checks++;
        if (state !== 3'b000 || draw_req !== 1'b0 || clear_hands !== 1'b0 || draw_target !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_values: state=%b req=%b clr=%b tgt=%b required 000/0/0/0",
                     state, draw_req, clear_hands, draw_target);
        end
        rst = 1'b0;
        repeat (6) begin
            tick();
            if (clear_hands !== 1'b0 || draw_req !== 1'b0 || state !== 3'b000) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("[TB] FAIL held_start_through_reset: activity=1 required 0");
        end
        btn_start = 1'b0;
        tick(2);
        start_round();
    endtask

    task automatic test_deal();
        exp_tgt_q.push_back(1'b0);
        exp_tgt_q.push_back(1'b1);
        exp_tgt_q.push_back(1'b0);
        serve(2, 5, 10);
        serve(2, 5, 10);
        serve(2, 15, 10);
        tick(2);
        checks++;
        if (state !== 3'b001) begin
            errors++;
            $display("[TB] FAIL deal_to_player: state=%b required 001", state);
        end
    endtask

    task automatic test_hit_stand_same();
        logic drew = 1'b0;
        dealer_score = 20;
        btn_hit = 1'b1;
        btn_stand = 1'b1;
        tick();
        btn_hit = 1'b0;
        btn_stand = 1'b0;
        tick();
        checks++;
        if (state !== 3'b010) begin
            errors++;
            $display("[TB] FAIL stand_priority: state=%b required 010", state);
        end
        repeat (4) begin
            tick();
            if (draw_req === 1'b1) drew = 1'b1;
        end
        checks++;
        if (drew || state !== 3'b100) begin
            errors++;
            $display("[TB] FAIL stand_resolve: drew=%b state=%b required 0/100", drew, state);
        end
    endtask

    task automatic test_player_bust();
        deal_round(12, 10);
        exp_tgt_q.push_back(1'b0);
        btn_hit = 1'b1;
        tick();
        btn_hit = 1'b0;
        serve(1, 23, 10);
        tick();
        checks++;
        if (state !== 3'b001) begin
            errors++;
            $display("[TB] FAIL bust_settle: state=%b required 001", state);
        end
        tick();
        checks++;
        if (state !== 3'b100) begin
            errors++;
            $display("[TB] FAIL bust_lose: state=%b required 100", state);
        end
    endtask

    task automatic test_dealer_draws();
        logic extra = 1'b0;
        deal_round(16, 12);
        exp_tgt_q.push_back(1'b0);
        btn_hit = 1'b1;
        serve(2, 18, 12);
        repeat (6) begin
            tick();
            if (draw_req === 1'b1) extra = 1'b1;
        end
        btn_hit = 1'b0;
        checks++;
        if (extra || state !== 3'b001) begin
            errors++;
            $display("[TB] FAIL held_hit_once: extra_req=%b state=%b required 0/001", extra, state);
        end
        tick();
        exp_tgt_q.push_back(1'b1);
        exp_tgt_q.push_back(1'b1);
        btn_stand = 1'b1;
        tick();
        btn_stand = 1'b0;
        serve(2, 18, 16);
        serve(2, 18, 18);
        tick(2);
        checks++;
        if (state !== 3'b101 || exp_tgt_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL dealer_draw: state=%b pending_exp=%0d required 101/0",
                     state, exp_tgt_q.size());
        end
        extra = 1'b0;
        repeat (3) begin
            tick();
            if (draw_req === 1'b1) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("[TB] FAIL dealer_extra_draw: extra_req=1 required 0");
        end
    endtask

    task automatic test_blackjack_win();
        logic drew = 1'b0;
        deal_round(21, 17);
        tick();
        checks++;
        if (state !== 3'b010) begin
            errors++;
            $display("[TB] FAIL auto_stand_21: state=%b required 010", state);
        end
        tick();
        checks++;
        if (state !== 3'b011) begin
            errors++;
            $display("[TB] FAIL win_vs_17: state=%b required 011", state);
        end
        btn_hit = 1'b1;
        tick();
        btn_hit = 1'b0;
        repeat (3) begin
            tick();
            if (draw_req === 1'b1) drew = 1'b1;
        end
        checks++;
        if (drew || state !== 3'b011) begin
            errors++;
            $display("[TB] FAIL win_hold: drew=%b state=%b required 0/011", drew, state);
        end
    endtask

    task automatic test_reset_mid();
        logic quiet = 1'b1;
        start_round();
        exp_tgt_q.push_back(1'b0);
        wait_req();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (draw_req !== 1'b0 || state !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_mid: draw_req=%b state=%b required 0/000", draw_req, state);
        end
        draw_ack = 1'b1;
        tick();
        draw_ack = 1'b0;
        repeat (5) begin
            tick();
            if (draw_req !== 1'b0 || state !== 3'b000) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("[TB] FAIL late_ack: activity=1 required 0");
        end
    endtask

    initial begin
        $display("[TB] game_fsm bench start");
        test_reset();
        test_deal();
        test_hit_stand_same();
        test_player_bust();
        test_dealer_draws();
        test_blackjack_win();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
